// File: rtl/axis_uart_pkg.sv
// Shared definitions for the AXI-Stream UART transmitter.
//   - Transmit FSM state encodings (IDLE, LOAD, START, DATA, PARITY, STOP)
//   - Parity mode selectors
//   - Bit-period calculation
package axis_uart_pkg;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLoad   = 3'd1;
    localparam logic [2:0] StStart  = 3'd2;
    localparam logic [2:0] StData   = 3'd3;
    localparam logic [2:0] StParity = 3'd4;
    localparam logic [2:0] StStop   = 3'd5;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Clocks per UART bit, truncated.
    function automatic int unsigned clock_duration(input int unsigned freq_hz,
                                                   input int unsigned baud);
        return freq_hz / baud;
    endfunction

endpackage

// File: rtl/fifo_in_sync_xpm.sv
// Synchronous first-word-fall-through queue with a byte-keep side path.
//   clk, reset      : clock, synchronous active-high reset (flushes the queue)
//   wr_en, din,
//   din_keep        : push side; a push while full is ignored
//   rd_en           : pop the head word; a pop while empty is ignored
//   dout, dout_keep : head word, valid whenever empty is low
//   full, empty     : occupancy flags
// MEMTYPE selects the intended memory style ("block"/"distributed"/"auto").
module fifo_in_sync_xpm #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter string       MEMTYPE    = "block"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic [DATA_WIDTH/8-1:0] din_keep,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic [DATA_WIDTH/8-1:0] dout_keep,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned KeepW = DATA_WIDTH / 8;
    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    if (MEMTYPE != "block" && MEMTYPE != "distributed" && MEMTYPE != "auto") begin : g_bad_memtype
        $error("fifo_in_sync_xpm: unsupported MEMTYPE");
    end

    logic [DATA_WIDTH+KeepW-1:0] mem [DEPTH];
    logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]             count_q;
    logic                        do_wr, do_rd;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    assign {dout_keep, dout} = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= {din_keep, din};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_wr && !do_rd) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_wr && do_rd) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/axis_uart_tx_frame.sv
// AXI-Stream fed UART transmitter. Each queued word is sent lane by lane (lowest
// lane first), one frame per lane whose TKEEP bit is set: start, DATA_BITS data
// bits LSB first, optional parity, STOP_BITS stop bits. Frames of a word are
// back to back; consecutive words are separated by two idle-high clocks.
//   clk, reset        : clock, synchronous active-high reset
//   S_AXIS_TDATA/TKEEP/TVALID/TREADY : input stream, TREADY = queue not full
//   UART_TX           : registered serial line, idle high
//   BUSY              : high while a word is being loaded or transmitted
// Build option: define AXIS_UART_TX_PARITY_EN to include the parity stage,
// which then honours PARITY_MODE (1 even, 2 odd).
module axis_uart_tx_frame
    import axis_uart_pkg::*;
#(
    parameter int unsigned FREQ_HZ       = 100000000,
    parameter int unsigned UART_SPEED    = 115200,
    parameter int unsigned N_BYTES       = 4,
    parameter int unsigned QUEUE_DEPTH   = 16,
    parameter string       QUEUE_MEMTYPE = "block",
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned STOP_BITS     = 1,
    parameter int unsigned PARITY_MODE   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BYTES*8-1:0] S_AXIS_TDATA,
    input  logic [N_BYTES-1:0]   S_AXIS_TKEEP,
    input  logic                 S_AXIS_TVALID,
    output logic                 S_AXIS_TREADY,
    output logic                 UART_TX,
    output logic                 BUSY
);

    localparam int unsigned ClkDur = clock_duration(FREQ_HZ, UART_SPEED);
    localparam int unsigned CntW   = (ClkDur > 1) ? $clog2(ClkDur) : 1;
    localparam int unsigned LaneW  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int unsigned DataW  = N_BYTES * 8;

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("axis_uart_tx_frame: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("axis_uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD)
    begin : g_bad_parity_mode
        $error("axis_uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end

    logic [DataW-1:0]   q_data;
    logic [N_BYTES-1:0] q_keep;
    logic               q_full, q_empty, q_pop;

    assign S_AXIS_TREADY = ~q_full & ~reset;

    fifo_in_sync_xpm #(
        .DATA_WIDTH (DataW),
        .DEPTH      (QUEUE_DEPTH),
        .MEMTYPE    (QUEUE_MEMTYPE)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (S_AXIS_TVALID & S_AXIS_TREADY),
        .din       (S_AXIS_TDATA),
        .din_keep  (S_AXIS_TKEEP),
        .rd_en     (q_pop),
        .dout      (q_data),
        .dout_keep (q_keep),
        .full      (q_full),
        .empty     (q_empty)
    );

    logic [2:0]         state_q, state_d;
    logic [CntW-1:0]    baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;   // data bit index, reused as stop bit index
    logic [LaneW-1:0]   lane_q, lane_d;
    logic [N_BYTES-1:0] mask_q, mask_d;
    logic [DataW-1:0]   data_q, data_d;
    logic               tx_q, tx_d;

    logic [7:0]         lane_byte;
    logic               baud_end;
    logic [N_BYTES-1:0] mask_rem;

    function automatic logic [LaneW-1:0] lowest_lane(input logic [N_BYTES-1:0] m);
        logic [LaneW-1:0] l;
        l = '0;
        for (int i = N_BYTES - 1; i >= 0; i--) begin
            if (m[i]) l = LaneW'(i);
        end
        return l;
    endfunction

    assign lane_byte = data_q[{lane_q, 3'b000} +: 8];
    assign baud_end  = (baud_q == CntW'(ClkDur - 1));
    assign mask_rem  = mask_q & ~(N_BYTES'(1) << lane_q);

`ifdef AXIS_UART_TX_PARITY_EN
    localparam int unsigned DataMaskI = (1 << DATA_BITS) - 1;
    localparam logic [7:0]  DataMask  = DataMaskI[7:0];
    localparam bit          ParityOn  = (PARITY_MODE == PAR_EVEN) || (PARITY_MODE == PAR_ODD);
    logic par_bit;
    assign par_bit = (^(lane_byte & DataMask)) ^ (PARITY_MODE == PAR_ODD);
`endif

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        lane_d  = lane_q;
        mask_d  = mask_q;
        data_d  = data_q;
        tx_d    = tx_q;
        q_pop   = 1'b0;
        // tx_d is set on every transition so UART_TX changes on the same edge as the state.
        case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!q_empty) state_d = StLoad;
            end
            StLoad: begin
                q_pop  = 1'b1;
                data_d = q_data;
                mask_d = q_keep;
                baud_d = '0;
                if (q_keep == '0) begin
                    state_d = StIdle;
                end else begin
                    state_d = StStart;
                    lane_d  = lowest_lane(q_keep);
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                    tx_d    = lane_byte[0];
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        bit_d = '0;
`ifdef AXIS_UART_TX_PARITY_EN
                        if (ParityOn) begin
                            state_d = StParity;
                            tx_d    = par_bit;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = lane_byte[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
`ifdef AXIS_UART_TX_PARITY_EN
            StParity: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StStop;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
`endif
            StStop: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'(STOP_BITS - 1)) begin
                        mask_d = mask_rem;
                        if (mask_rem != '0) begin
                            state_d = StStart;
                            lane_d  = lowest_lane(mask_rem);
                            tx_d    = 1'b0;
                        end else begin
                            state_d = StIdle;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            lane_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            lane_q  <= lane_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    assign UART_TX = tx_q;
    assign BUSY    = (state_q != StIdle);

endmodule
